stable_timer_unit: RTL and testbench

STABLE_TIMER_UNIT -- requirements
Module: stable_timer_unit

---
 rtl/stable_timer_unit.sv | 122 ++++++++++++
 tb/tb_stable_timer_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stable_timer_unit.sv
// Free-running stable counter plus N_TIMER independent countdown channels with pending interrupts.
// Define TIMER_HALT_EN to add a debug halt input that freezes the counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | channel disabled, tval holds its value
// ST_COUNT | channel enabled, tval counts down; expiry at tval == 0
module stable_timer_unit #(
  parameter int CNT_WIDTH  = 64,
  parameter int TVAL_WIDTH = 32,
  parameter int N_TIMER    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
`ifdef TIMER_HALT_EN
  input  logic                  halt,
`endif
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_sel,
  input  logic [TVAL_WIDTH-1:0] cfg_wdata,
  input  logic                  clr_we,
  input  logic [2:0]            clr_sel,
  input  logic [2:0]            rd_sel,
  output logic [TVAL_WIDTH-1:0] rd_tcfg,
  output logic [TVAL_WIDTH-1:0] rd_tval,
  output logic [CNT_WIDTH-1:0]  stable_cnt,
  output logic [N_TIMER-1:0]    timer_int
);

  typedef enum logic {ST_IDLE = 1'b0, ST_COUNT = 1'b1} state_t;

  state_t                state_q [N_TIMER];
  state_t                state_d [N_TIMER];
  logic [TVAL_WIDTH-1:0] tcfg_q  [N_TIMER];
  logic [TVAL_WIDTH-1:0] tcfg_d  [N_TIMER];
  logic [TVAL_WIDTH-1:0] tval_q  [N_TIMER];
  logic [TVAL_WIDTH-1:0] tval_d  [N_TIMER];
  logic [N_TIMER-1:0]    pend_q;
  logic [N_TIMER-1:0]    pend_d;
  logic [N_TIMER-1:0]    cfg_hit;
  logic [N_TIMER-1:0]    clr_hit;
  logic [N_TIMER-1:0]    expire;
  logic                  run;

`ifdef TIMER_HALT_EN
  assign run = ~halt;
`else
  assign run = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable_cnt <= '0;
      pend_q     <= '0;
      for (int i = 0; i < N_TIMER; i++) begin
        state_q[i] <= ST_IDLE;
        tcfg_q[i]  <= '0;
        tval_q[i]  <= '0;
      end
    end else begin
      if (run) stable_cnt <= stable_cnt + CNT_WIDTH'(1);
      pend_q <= pend_d;
      for (int i = 0; i < N_TIMER; i++) begin
        state_q[i] <= state_d[i];
        tcfg_q[i]  <= tcfg_d[i];
        tval_q[i]  <= tval_d[i];
      end
    end
  end

  // Selects >= N_TIMER match no channel, so out-of-range writes fall through.
  always_comb begin
    cfg_hit = '0;
    clr_hit = '0;
    expire  = '0;
    pend_d  = pend_q;
    for (int i = 0; i < N_TIMER; i++) begin
      state_d[i] = state_q[i];
      tcfg_d[i]  = tcfg_q[i];
      tval_d[i]  = tval_q[i];
      cfg_hit[i] = cfg_we && (cfg_sel == 3'(i));
      clr_hit[i] = clr_we && (clr_sel == 3'(i));

      if (cfg_hit[i]) begin
        tcfg_d[i]  = cfg_wdata;
        tval_d[i]  = {cfg_wdata[TVAL_WIDTH-1:2], 2'b00};
        state_d[i] = cfg_wdata[0] ? ST_COUNT : ST_IDLE;
      end else if (state_q[i] == ST_COUNT && run) begin
        if (tval_q[i] != '0) begin
          tval_d[i] = tval_q[i] - TVAL_WIDTH'(1);
        end else begin
          expire[i] = 1'b1;
          if (tcfg_q[i][1]) begin
            tval_d[i] = {tcfg_q[i][TVAL_WIDTH-1:2], 2'b00};
          end else begin
            tval_d[i]    = '1;
            tcfg_d[i][0] = 1'b0;
            state_d[i]   = ST_IDLE;
          end
        end
      end

      // Set beats clear when both land on the same edge.
      if (expire[i])       pend_d[i] = 1'b1;
      else if (clr_hit[i]) pend_d[i] = 1'b0;
    end
  end

  assign timer_int = pend_q;

  always_comb begin
    rd_tcfg = '0;
    rd_tval = '0;
    for (int i = 0; i < N_TIMER; i++) begin
      if (rd_sel == 3'(i)) begin
        rd_tcfg = tcfg_q[i];
        rd_tval = tval_q[i];
      end
    end
  end

endmodule

// File: tb/tb_stable_timer_unit.sv
// Directed bench for stable_timer_unit (8-bit stable counter, two 32-bit channels).
// Exercises the halt path too when built with TIMER_HALT_EN.
module tb_stable_timer_unit;
  localparam int TW = 32;
  localparam int NT = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          halt = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_sel = '0;
  logic [TW-1:0] cfg_wdata = '0;
  logic          clr_we = 1'b0;
  logic [2:0]    clr_sel = '0;
  logic [2:0]    rd_sel = '0;
  logic [TW-1:0] rd_tcfg;
  logic [TW-1:0] rd_tval;
  logic [CW-1:0] stable_cnt;
  logic [NT-1:0] timer_int;
  logic [CW-1:0] exp_cnt = '0;
  int            n_total = 0;
  int            n_bad = 0;

  stable_timer_unit #(.CNT_WIDTH(CW), .TVAL_WIDTH(TW), .N_TIMER(NT)) dut (
    .clk        (clk),
    .resetn     (resetn),
`ifdef TIMER_HALT_EN
    .halt       (halt),
`endif
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_wdata  (cfg_wdata),
    .clr_we     (clr_we),
    .clr_sel    (clr_sel),
    .rd_sel     (rd_sel),
    .rd_tcfg    (rd_tcfg),
    .rd_tval    (rd_tval),
    .stable_cnt (stable_cnt),
    .timer_int  (timer_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model of the stable counter advances only on edges where the DUT should count.
  task automatic tick();
    @(posedge clk);
    if (resetn && !halt) exp_cnt = exp_cnt + 8'd1;
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg_wr(input logic [2:0] sel, input logic [TW-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
    #1;
  endtask

  task automatic clr_wr(input logic [2:0] sel);
    clr_we = 1'b1; clr_sel = sel;
    tick();
    clr_we = 1'b0;
    #1;
  endtask

  initial begin
    tick_n(2);
    chk("rst_cnt",  64'(stable_cnt), 64'd0);
    chk("rst_int",  64'(timer_int),  64'd0);
    chk("rst_tval", 64'(rd_tval),    64'd0);
    chk("rst_tcfg", 64'(rd_tcfg),    64'd0);

    resetn = 1'b1;
    tick_n(10);
    chk("cnt_after10", 64'(stable_cnt), 64'd10);
    for (int ch = 0; ch < NT; ch++) begin
      rd_sel = 3'(ch); #1;
      chk("idle_tval", 64'(rd_tval), 64'd0);
    end
    rd_sel = 3'd5; #1;
    chk("oob_rd_tval", 64'(rd_tval), 64'd0);

    // one-shot ch0, InitVal=3
    rd_sel = 3'd0;
    cfg_wr(3'd0, 32'h0000_000D);
    chk("os_load",  64'(rd_tval), 64'd12);
    chk("os_tcfg",  64'(rd_tcfg), 64'hD);
    for (int k = 11; k >= 0; k--) begin
      tick();
      chk("os_tval", 64'(rd_tval), 64'(k));
    end
    chk("os_early", 64'(timer_int[0]), 64'd0);
    tick();
    chk("os_int",  64'(timer_int[0]), 64'd1);
    chk("os_wrap", 64'(rd_tval), 64'hFFFF_FFFF);
    chk("os_tcfg_en", 64'(rd_tcfg), 64'hC);
    tick();
    chk("os_hold", 64'(rd_tval), 64'hFFFF_FFFF);
    clr_wr(3'd2);
    chk("clr_oob", 64'(timer_int[0]), 64'd1);
    cfg_wr(3'd3, 32'h0000_0005);
    chk("cfg_oob_ch0", 64'(rd_tcfg), 64'hC);
    rd_sel = 3'd3; #1;
    chk("oob_rd_tcfg", 64'(rd_tcfg), 64'd0);
    clr_wr(3'd0);
    chk("clr_ch0", 64'(timer_int), 64'd0);

    // periodic ch1, InitVal=1, period 5
    rd_sel = 3'd1;
    cfg_wr(3'd1, 32'h0000_0007);
    chk("per_load", 64'(rd_tval), 64'd4);
    tick_n(4);
    chk("per_zero", 64'(rd_tval), 64'd0);
    chk("per_early", 64'(timer_int[1]), 64'd0);
    tick();
    chk("per_int1", 64'(timer_int[1]), 64'd1);
    chk("per_reload", 64'(rd_tval), 64'd4);
    clr_wr(3'd1);
    chk("per_clr", 64'(timer_int[1]), 64'd0);
    tick_n(3);
    chk("per_gap", 64'(timer_int[1]), 64'd0);
    tick();
    chk("per_int2", 64'(timer_int[1]), 64'd1);
    tick_n(4);
    chk("per_zero2", 64'(rd_tval), 64'd0);
    clr_wr(3'd1);
    chk("clr_vs_set", 64'(timer_int[1]), 64'd1);
    chk("per_reload2", 64'(rd_tval), 64'd4);
    cfg_wr(3'd1, 32'h0);
    clr_wr(3'd1);
    chk("per_off", 64'(timer_int), 64'd0);

    // cfg write coinciding with expiry
    rd_sel = 3'd0;
    cfg_wr(3'd0, 32'h0000_0005);
    tick_n(4);
    chk("prec_zero", 64'(rd_tval), 64'd0);
    cfg_wr(3'd0, 32'h0000_0011);
    chk("prec_noint", 64'(timer_int[0]), 64'd0);
    chk("prec_tval", 64'(rd_tval), 64'h10);
    tick();
    chk("prec_dec", 64'(rd_tval), 64'hF);
    tick_n(15);
    chk("prec_int_early", 64'(timer_int[0]), 64'd0);
    tick();
    chk("prec_int", 64'(timer_int[0]), 64'd1);
    clr_wr(3'd0);

    // simultaneous expiry on both channels
    cfg_wr(3'd0, 32'h0000_0009);
    tick_n(3);
    cfg_wr(3'd1, 32'h0000_0005);
    tick_n(4);
    chk("sim_early", 64'(timer_int), 64'd0);
    tick();
    chk("sim_both", 64'(timer_int), 64'd3);
    clr_wr(3'd0);
    clr_wr(3'd1);
    chk("sim_clr", 64'(timer_int), 64'd0);
    chk("cnt_model", 64'(stable_cnt), 64'(exp_cnt));

`ifdef TIMER_HALT_EN
    rd_sel = 3'd0;
    cfg_wr(3'd0, 32'h0000_000D);
    tick_n(3);
    chk("halt_pre", 64'(rd_tval), 64'd9);
    halt = 1'b1;
    tick_n(10);
    cfg_wr(3'd1, 32'h0000_0004);
    tick_n(9);
    chk("halt_cnt", 64'(stable_cnt), 64'(exp_cnt));
    chk("halt_tval", 64'(rd_tval), 64'd9);
    rd_sel = 3'd1; #1;
    chk("halt_cfg", 64'(rd_tcfg), 64'h4);
    chk("halt_cfg_tval", 64'(rd_tval), 64'h4);
    rd_sel = 3'd0;
    halt = 1'b0;
    tick_n(9);
    chk("halt_int_early", 64'(timer_int[0]), 64'd0);
    tick();
    chk("halt_int", 64'(timer_int[0]), 64'd1);
    clr_wr(3'd0);
    cfg_wr(3'd1, 32'h0);
`endif

    // stable counter wrap
    for (int k = 0; k < 300 && exp_cnt != 8'hFF; k++) tick();
    chk("wrap_pre", 64'(stable_cnt), 64'hFF);
    tick();
    chk("wrap_zero", 64'(stable_cnt), 64'd0);

    // reset in the middle of a count
    rd_sel = 3'd0;
    cfg_wr(3'd0, 32'h0000_000D);
    tick_n(5);
    resetn = 1'b0;
    exp_cnt = '0;
    #1;
    chk("mid_rst_cnt",  64'(stable_cnt), 64'd0);
    chk("mid_rst_tval", 64'(rd_tval),    64'd0);
    chk("mid_rst_tcfg", 64'(rd_tcfg),    64'd0);
    chk("mid_rst_int",  64'(timer_int),  64'd0);
    tick();
    resetn = 1'b1;
    tick_n(30);
    chk("post_rst_int",  64'(timer_int),  64'd0);
    chk("post_rst_tval", 64'(rd_tval),    64'd0);
    chk("post_rst_cnt",  64'(stable_cnt), 64'd30);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
